// File: rtl/nasti_sram_writer.sv
// nasti_sram_writer
//   NASTI write-channel slave that terminates INCR write bursts onto a simple
//   byte-addressed SRAM write port. One transaction in flight, one B per burst.
//
// Ports
//   clk, rstn                      clock, asynchronous active-low reset
//   nasti_aw_*                     write address channel (lock/cache/prot/qos/region ignored)
//   nasti_w_*                      write data channel (w_user ignored)
//   nasti_b_*                      write response channel
//   mem_we/addr/wdata/strb         SRAM write request; write happens when mem_we && mem_ready
//   mem_ready                      SRAM accepts the write this cycle
module nasti_sram_writer #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  // AW
  input  logic [ID_WIDTH-1:0]     nasti_aw_id,
  input  logic [ADDR_WIDTH-1:0]   nasti_aw_addr,
  input  logic [7:0]              nasti_aw_len,
  input  logic [2:0]              nasti_aw_size,
  input  logic [1:0]              nasti_aw_burst,
  input  logic                    nasti_aw_lock,
  input  logic [3:0]              nasti_aw_cache,
  input  logic [2:0]              nasti_aw_prot,
  input  logic [3:0]              nasti_aw_qos,
  input  logic [3:0]              nasti_aw_region,
  input  logic [USER_WIDTH-1:0]   nasti_aw_user,
  input  logic                    nasti_aw_valid,
  output logic                    nasti_aw_ready,
  // W
  input  logic [DATA_WIDTH-1:0]   nasti_w_data,
  input  logic [DATA_WIDTH/8-1:0] nasti_w_strb,
  input  logic                    nasti_w_last,
  input  logic [USER_WIDTH-1:0]   nasti_w_user,
  input  logic                    nasti_w_valid,
  output logic                    nasti_w_ready,
  // B
  output logic [ID_WIDTH-1:0]     nasti_b_id,
  output logic [1:0]              nasti_b_resp,
  output logic [USER_WIDTH-1:0]   nasti_b_user,
  output logic                    nasti_b_valid,
  input  logic                    nasti_b_ready,
  // SRAM
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_strb,
  input  logic                    mem_ready
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [USER_WIDTH-1:0]   user_q, user_d;
  logic [7:0]              beat_q, beat_d;
  logic                    err_q, err_d;

  logic                    last_beat;
  logic [ADDR_WIDTH-1:0]   beat_bytes;

  // Ignored sideband fields, folded together so they are visibly consumed.
  logic unused_sideband;
  assign unused_sideband = ^{nasti_aw_lock, nasti_aw_cache, nasti_aw_prot,
                             nasti_aw_qos, nasti_aw_region, nasti_w_user};

  assign last_beat  = (beat_q == len_q);
  assign beat_bytes = ADDR_WIDTH'(1) << size_q;

  // Data path is a straight pass-through; the master positions narrow strobes.
  assign mem_addr     = addr_q;
  assign mem_wdata    = nasti_w_data;
  assign mem_strb     = nasti_w_strb;
  assign nasti_b_id   = id_q;
  assign nasti_b_user = user_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    id_d           = id_q;
    addr_d         = addr_q;
    len_d          = len_q;
    size_d         = size_q;
    user_d         = user_q;
    beat_d         = beat_q;
    err_d          = err_q;
    nasti_aw_ready = 1'b0;
    nasti_w_ready  = 1'b0;
    nasti_b_valid  = 1'b0;
    nasti_b_resp   = 2'b00;
    mem_we         = 1'b0;

    unique case (state_q)
      IDLE: begin
        nasti_aw_ready = 1'b1;
        if (nasti_aw_valid) begin
          id_d    = nasti_aw_id;
          addr_d  = nasti_aw_addr;
          len_d   = nasti_aw_len;
          size_d  = nasti_aw_size;
          user_d  = nasti_aw_user;
          beat_d  = 8'd0;
          err_d   = (nasti_aw_burst != 2'b01) || (nasti_aw_size > 3'(MAX_SIZE));
          state_d = DATA;
        end
      end

      DATA: begin
        // After an error, beats are drained without waiting on the SRAM.
        nasti_w_ready = err_q || mem_ready;
        mem_we        = nasti_w_valid && !err_q;
        if (nasti_w_valid && nasti_w_ready) begin
          beat_d = beat_q + 8'd1;
          // Align down then step: an unaligned start only affects beat 0.
          addr_d = (addr_q & ~(beat_bytes - ADDR_WIDTH'(1))) + beat_bytes;
          if (nasti_w_last != last_beat) err_d = 1'b1;
          // Beat count alone ends the burst; w_last only flags errors.
          if (last_beat) state_d = RESP;
        end
      end

      RESP: begin
        nasti_b_valid = 1'b1;
        nasti_b_resp  = err_q ? 2'b10 : 2'b00;
        if (nasti_b_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      user_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      user_q  <= user_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_nasti_sram_writer.sv
// Directed self-checking bench for nasti_sram_writer (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are checked just
// before the next edge. SRAM writes are logged at each edge and compared
// against hand-computed address/data lists.
module tb_nasti_sram_writer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [0:0]  aw_id;
  logic [7:0]  aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [0:0]  aw_user;
  logic        aw_valid, aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic [0:0]  w_user;
  logic        w_valid, w_ready;
  logic [0:0]  b_id;
  logic [1:0]  b_resp;
  logic [0:0]  b_user;
  logic        b_valid, b_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic        mem_ready;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_n = 0;

  nasti_sram_writer dut (
    .clk(clk), .rstn(rstn),
    .nasti_aw_id(aw_id), .nasti_aw_addr(aw_addr), .nasti_aw_len(aw_len),
    .nasti_aw_size(aw_size), .nasti_aw_burst(aw_burst), .nasti_aw_lock(1'b0),
    .nasti_aw_cache(4'h0), .nasti_aw_prot(3'h0), .nasti_aw_qos(4'h0),
    .nasti_aw_region(4'h0), .nasti_aw_user(aw_user), .nasti_aw_valid(aw_valid),
    .nasti_aw_ready(aw_ready),
    .nasti_w_data(w_data), .nasti_w_strb(w_strb), .nasti_w_last(w_last),
    .nasti_w_user(w_user), .nasti_w_valid(w_valid), .nasti_w_ready(w_ready),
    .nasti_b_id(b_id), .nasti_b_resp(b_resp), .nasti_b_user(b_user),
    .nasti_b_valid(b_valid), .nasti_b_ready(b_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_strb(mem_strb), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we && mem_ready && wr_n < 64) begin
      wr_addr[wr_n] <= mem_addr;
      wr_data[wr_n] <= mem_wdata;
      wr_n          <= wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [0:0] id, input logic [7:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
    aw_user = id; aw_valid = 1'b1;
    #1 check("aw_ready_idle", aw_ready, 1'b1);
    tick();
    aw_valid = 1'b0;
    check("aw_ready_busy", aw_ready, 1'b0);
  endtask

  // Presents one beat and waits (bounded) for the handshake edge.
  task automatic do_w(input logic [31:0] data, input logic last);
    int n;
    w_data = data; w_strb = 4'hF; w_last = last; w_valid = 1'b1;
    #1;
    n = 0;
    while (!w_ready && n < 20) begin
      tick();
      n++;
    end
    check("w_handshake_timeout", n < 20, 1'b1);
    tick();
    w_valid = 1'b0;
  endtask

  // B must already be valid (cycle after the last W handshake).
  task automatic do_b(input logic [0:0] id, input logic [1:0] resp);
    check("b_valid", b_valid, 1'b1);
    check("b_id", b_id, id);
    check("b_user", b_user, id);
    check("b_resp", b_resp, resp);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("aw_ready_after_b", aw_ready, 1'b1);
    check("b_valid_after_b", b_valid, 1'b0);
  endtask

  initial begin
    int base;
    rstn = 1'b0; aw_valid = 1'b0; w_valid = 1'b1; b_ready = 1'b0; mem_ready = 1'b1;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = 2'b01; aw_user = '0;
    w_data = 32'h1234_5678; w_strb = 4'hF; w_last = 1'b0; w_user = '0;

    // Reset state, with W valid offered in IDLE.
    tick(); tick();
    check("rst_aw_ready", aw_ready, 1'b1);
    check("rst_w_ready", w_ready, 1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_b_resp", b_resp, 2'b00);
    check("rst_mem_we", mem_we, 1'b0);
    rstn = 1'b1;
    tick();
    check("idle_w_ready", w_ready, 1'b0);
    check("idle_mem_we", mem_we, 1'b0);
    w_valid = 1'b0;

    // 1: single beat at 0x10.
    base = wr_n;
    do_aw(1'b1, 8'h10, 8'd0, 3'd2, 2'b01);
    check("t1_mem_addr", mem_addr, 8'h10);
    w_data = 32'hDEAD_BEEF; w_valid = 1'b1; w_last = 1'b1;
    #1 check("t1_mem_we", mem_we, 1'b1);
    check("t1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    do_w(32'hDEAD_BEEF, 1'b1);
    do_b(1'b1, 2'b00);
    check("t1_wr_count", wr_n - base, 1);
    check("t1_wr_addr", wr_addr[base], 8'h10);
    check("t1_wr_data", wr_data[base], 32'hDEAD_BEEF);

    // 2: unaligned start, 4 beats: 0x02, 0x04, 0x08, 0x0C.
    base = wr_n;
    do_aw(1'b0, 8'h02, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) do_w(32'hA000_0000 + i, i == 3);
    do_b(1'b0, 2'b00);
    check("t2_wr_count", wr_n - base, 4);
    check("t2_addr0", wr_addr[base],   8'h02);
    check("t2_addr1", wr_addr[base+1], 8'h04);
    check("t2_addr2", wr_addr[base+2], 8'h08);
    check("t2_addr3", wr_addr[base+3], 8'h0C);
    check("t2_data3", wr_data[base+3], 32'hA000_0003);

    // 3: address wrap 0xF8, 0xFC, 0x00.
    base = wr_n;
    do_aw(1'b1, 8'hF8, 8'd2, 3'd2, 2'b01);
    for (int i = 0; i < 3; i++) do_w(32'hB000_0000 + i, i == 2);
    do_b(1'b1, 2'b00);
    check("t3_wr_count", wr_n - base, 3);
    check("t3_addr0", wr_addr[base],   8'hF8);
    check("t3_addr1", wr_addr[base+1], 8'hFC);
    check("t3_addr2", wr_addr[base+2], 8'h00);

    // 4: WRAP burst -> drained without writes, even with SRAM not ready.
    base = wr_n;
    mem_ready = 1'b0;
    do_aw(1'b0, 8'h40, 8'd1, 3'd2, 2'b10);
    w_valid = 1'b1;
    #1 check("t4_w_ready_err", w_ready, 1'b1);
    check("t4_mem_we", mem_we, 1'b0);
    for (int i = 0; i < 2; i++) do_w(32'hC000_0000 + i, i == 1);
    mem_ready = 1'b1;
    do_b(1'b0, 2'b10);
    check("t4_wr_count", wr_n - base, 0);

    // 5: early w_last on beat 1 -> beats 0,1 written, 2,3 dropped.
    base = wr_n;
    do_aw(1'b1, 8'h20, 8'd3, 3'd2, 2'b01);
    do_w(32'hD000_0000, 1'b0);
    do_w(32'hD000_0001, 1'b1);
    w_valid = 1'b1;
    #1 check("t5_mem_we_after_err", mem_we, 1'b0);
    do_w(32'hD000_0002, 1'b0);
    check("t5_b_not_early", b_valid, 1'b0);
    do_w(32'hD000_0003, 1'b1);
    do_b(1'b1, 2'b10);
    check("t5_wr_count", wr_n - base, 2);
    check("t5_addr1", wr_addr[base+1], 8'h24);
    check("t5_data1", wr_data[base+1], 32'hD000_0001);

    // 6: SRAM stall mid-burst, then B backpressure, then a second AW.
    base = wr_n;
    do_aw(1'b0, 8'h30, 8'd2, 3'd2, 2'b01);
    do_w(32'hE000_0000, 1'b0);
    mem_ready = 1'b0;
    w_data = 32'hE000_0001; w_last = 1'b0; w_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_stall_w_ready", w_ready, 1'b0);
      check("t6_stall_mem_addr", mem_addr, 8'h34);
      check("t6_stall_mem_wdata", mem_wdata, 32'hE000_0001);
      check("t6_stall_aw_ready", aw_ready, 1'b0);
      tick();
    end
    check("t6_stall_wr_count", wr_n - base, 1);
    mem_ready = 1'b1;
    do_w(32'hE000_0001, 1'b0);
    do_w(32'hE000_0002, 1'b1);
    for (int i = 0; i < 2; i++) begin
      check("t6_b_hold_valid", b_valid, 1'b1);
      check("t6_b_hold_id", b_id, 1'b0);
      check("t6_b_hold_resp", b_resp, 2'b00);
      check("t6_b_hold_aw_ready", aw_ready, 1'b0);
      tick();
    end
    do_b(1'b0, 2'b00);
    check("t6_wr_count", wr_n - base, 3);
    check("t6_addr2", wr_addr[base+2], 8'h38);
    do_aw(1'b1, 8'h50, 8'd0, 3'd2, 2'b01);
    check("t6_second_aw_data", w_ready, 1'b1);

    // 7: reset mid-burst abandons the transaction with no B.
    rstn = 1'b0;
    #1;
    check("t7_rst_aw_ready", aw_ready, 1'b1);
    check("t7_rst_w_ready", w_ready, 1'b0);
    tick();
    rstn = 1'b1;
    tick();
    check("t7_no_b", b_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
